// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI burst sequencer: FSM encoding, MMIO word map,
// status bit positions and burst limits.
// No logic; constants and a length-clamp helper only.
package spi_seq_pkg;

   // FSM state encoding
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_CS_SETUP   = 3'd1;
   localparam logic [2:0] S_LOAD       = 3'd2;
   localparam logic [2:0] S_WAIT_START = 3'd3;
   localparam logic [2:0] S_WAIT_DONE  = 3'd4;
   localparam logic [2:0] S_CAPTURE    = 3'd5;
   localparam logic [2:0] S_CS_HOLD    = 3'd6;
   localparam logic [2:0] S_FINISH     = 3'd7;

   // Word indices on the SPI master peripheral
   localparam logic [7:0] WRITE_DATA      = 8'h01;
   localparam logic [7:0] READ_AND_STATUS = 8'h04;

   // Status word bit positions (bits 7:0 carry the received byte)
   localparam int READY_BIT = 8;
   localparam int BUSY_BIT  = 9;

   localparam int MAX_BURST = 16;
   localparam int TIMER_W   = 16;

   // Bursts longer than MAX_BURST are truncated, never wrapped.
   function automatic logic [4:0] clamp_len(input logic [4:0] len);
      return (len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : len;
   endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable saturating down-counter with a zero flag.
// Latency: count visible the cycle after load; zero asserted once count reaches 0.
// Backpressure: none; counts every cycle, holds at zero.
// Ports: clk, rst (sync, active-high), load/load_val (reload), zero (count == 0).
module spi_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/spi_burst_sequencer.sv
// Runs a burst of 1..16 SPI bytes through an MMIO SPI master: chip select framing,
// byte write, busy polling with start timeout, and received-byte capture.
// Latency: write 1 cycle after tx accept; rx_valid 1 cycle after busy falls.
// Backpressure: tx_ready only in LOAD; rx_valid/done are unthrottled pulses.
// Ports: cmd_valid/cmd_ready/cmd_len (burst request), tx_valid/tx_ready/tx_data
// (outgoing bytes), rx_valid/rx_data (received bytes), done/error/busy (status),
// spi_cs_n, spi_addr/spi_wr_en/spi_wr_data/spi_rd_data (peripheral MMIO port).
module spi_burst_sequencer
   import spi_seq_pkg::*;
#(
   parameter int CS_SETUP_CYCLES = 2,
   parameter int CS_HOLD_CYCLES  = 2,
   parameter int START_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_len,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        done,
   output logic        error,
   output logic        busy,
   output logic        spi_cs_n,
   output logic [7:0]  spi_addr,
   output logic [3:0]  spi_wr_en,
   output logic [31:0] spi_wr_data,
   input  logic [31:0] spi_rd_data
);

   logic [2:0]         state, state_nxt;
   logic [4:0]         rem;
   logic               err_flag, err_set;
   logic               t_load, t_zero;
   logic [TIMER_W-1:0] t_val;
   logic               wr_now, st_busy, capture_now;
   logic               rd_unused;

   spi_seq_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   assign cmd_ready = (state == S_IDLE);
   assign tx_ready  = (state == S_LOAD);
   assign busy      = (state != S_IDLE);

   assign wr_now      = (state == S_LOAD) && tx_valid;
   assign st_busy     = spi_rd_data[BUSY_BIT];
   assign capture_now = (state == S_WAIT_DONE) && (state_nxt == S_CAPTURE);
   // Ready and upper status bits carry nothing the sequencer acts on.
   assign rd_unused   = ^{spi_rd_data[31:10], spi_rd_data[READY_BIT]};

   // A timer reload of N keeps the state for N+1 cycles (N counts plus the zero cycle).
   always_comb begin
      state_nxt = state;
      t_load    = 1'b0;
      t_val     = '0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == 5'd0) begin
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt = S_CS_SETUP;
                  t_load    = 1'b1;
                  t_val     = TIMER_W'(CS_SETUP_CYCLES);
               end
            end
         end
         S_CS_SETUP: begin
            if (t_zero) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (tx_valid) begin
               state_nxt = S_WAIT_START;
               t_load    = 1'b1;
               t_val     = TIMER_W'(START_TIMEOUT);
            end
         end
         S_WAIT_START: begin
            // During the write cycle spi_addr points at WRITE_DATA, so the
            // status read is meaningless and busy is not sampled.
            if ((spi_wr_en == 4'b0000) && st_busy) begin
               state_nxt = S_WAIT_DONE;
            end else if (t_zero) begin
               state_nxt = S_CS_HOLD;
               err_set   = 1'b1;
               t_load    = 1'b1;
               t_val     = TIMER_W'(CS_HOLD_CYCLES);
            end
         end
         S_WAIT_DONE: begin
            if (!st_busy) state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (rem <= 5'd1) begin
               state_nxt = S_CS_HOLD;
               t_load    = 1'b1;
               t_val     = TIMER_W'(CS_HOLD_CYCLES);
            end else begin
               state_nxt = S_LOAD;
            end
         end
         S_CS_HOLD: begin
            if (t_zero) state_nxt = S_FINISH;
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rem         <= 5'd0;
         err_flag    <= 1'b0;
         spi_cs_n    <= 1'b1;
         spi_addr    <= READ_AND_STATUS;
         spi_wr_en   <= 4'b0000;
         spi_wr_data <= 32'h0;
         rx_valid    <= 1'b0;
         rx_data     <= 8'h00;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state <= state_nxt;

         if ((state == S_IDLE) && cmd_valid) begin
            rem <= clamp_len(cmd_len);
         end else if ((state == S_CAPTURE) && (rem != 5'd0)) begin
            rem <= rem - 5'd1;
         end

         if (state == S_FINISH) begin
            err_flag <= 1'b0;
         end else if (err_set) begin
            err_flag <= 1'b1;
         end

         // Registered outputs are computed from the next state so they line up
         // with the state they belong to.
         spi_cs_n    <= (state_nxt == S_IDLE) || (state_nxt == S_FINISH);
         spi_wr_en   <= wr_now ? 4'b0001 : 4'b0000;
         spi_addr    <= wr_now ? WRITE_DATA : READ_AND_STATUS;
         spi_wr_data <= wr_now ? {24'h0, tx_data} : 32'h0;

         rx_valid <= capture_now;
         if (capture_now) rx_data <= spi_rd_data[7:0];

         done  <= (state_nxt == S_FINISH);
         error <= (state_nxt == S_FINISH) && err_flag;
      end
   end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
module tb_spi_burst_sequencer;

   localparam int SETUP   = 2;
   localparam int HOLD    = 2;
   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [4:0]  cmd_len = 5'd0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  tx_data = 8'h00;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        done, error, busy;
   logic        spi_cs_n;
   logic [7:0]  spi_addr;
   logic [3:0]  spi_wr_en;
   logic [31:0] spi_wr_data;
   logic [31:0] spi_rd_data;

   spi_burst_sequencer #(
      .CS_SETUP_CYCLES (SETUP),
      .CS_HOLD_CYCLES  (HOLD),
      .START_TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_len     (cmd_len),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .done        (done),
      .error       (error),
      .busy        (busy),
      .spi_cs_n    (spi_cs_n),
      .spi_addr    (spi_addr),
      .spi_wr_en   (spi_wr_en),
      .spi_wr_data (spi_wr_data),
      .spi_rd_data (spi_rd_data)
   );

   always #5 clk = ~clk;

   // Peripheral model: byte loops MOSI to MISO. Busy rises 3 cycles after the
   // write cycle, stays high 4 cycles; rx byte updates as busy falls.
   int         per_cnt = 0;
   logic [7:0] per_sh = 8'h00;
   logic [7:0] per_rx = 8'h00;
   bit         per_nobusy = 1'b0;
   logic       per_busy;

   assign per_busy = !per_nobusy && (per_cnt >= 1) && (per_cnt <= 4);
   assign spi_rd_data = (spi_addr == 8'h04) ? {22'h0, per_busy, ~per_busy, per_rx} : 32'h0;

   always @(posedge clk) begin
      if (spi_wr_en[0] && (spi_addr == 8'h01)) begin
         per_sh  <= spi_wr_data[7:0];
         per_cnt <= 6;
      end else if (per_cnt > 0) begin
         per_cnt <= per_cnt - 1;
         if (per_cnt == 1) per_rx <= per_sh;
      end
   end

   // Monitor: cycle counter plus logs of DUT activity.
   int         cyc = 0;
   int         wr_cnt = 0, rx_cnt = 0, done_cnt = 0, cs_low_cnt = 0, cs_bad = 0;
   int         wr_cyc = 0, done_cyc = 0;
   logic       done_err = 1'b0, done_cs = 1'b0;
   logic [7:0] wr_log[$];
   logic [7:0] rx_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (spi_wr_en != 4'b0000) begin
         wr_cnt++;
         wr_cyc = cyc;
         wr_log.push_back(spi_wr_data[7:0]);
      end
      if (rx_valid) begin
         rx_cnt++;
         rx_log.push_back(rx_data);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = error;
         done_cs  = spi_cs_n;
      end
      if (!spi_cs_n) cs_low_cnt++;
      if (spi_cs_n && ((spi_wr_en != 4'b0000) || rx_valid || per_busy)) cs_bad++;
   end

   int         checks = 0;
   int         errors = 0;
   logic [7:0] txq[$];
   bit         tx_en = 1'b0;
   bit         acc_flag = 1'b0;
   int         acc_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe handshakes before the edge, update drivers after it.
   task automatic cyc_step();
      bit hs, ch;
      @(negedge clk);
      hs = tx_valid && tx_ready;
      ch = cmd_valid && cmd_ready;
      if (ch) acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (hs && (txq.size() != 0)) void'(txq.pop_front());
      if (ch) begin
         cmd_valid = 1'b0;
         acc_flag  = 1'b1;
      end
      tx_valid = tx_en && (txq.size() != 0);
      tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
   endtask

   task automatic send_cmd(input string tag, input logic [4:0] len);
      acc_flag  = 1'b0;
      cmd_len   = len;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !acc_flag; i++) cyc_step();
      cmd_valid = 1'b0;
      check({tag, "_accept"}, 32'(acc_flag), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int base, n;
      base = done_cnt;
      n = 0;
      while ((done_cnt == base) && (n < budget)) begin
         cyc_step();
         n++;
      end
      check({tag, "_done_pulses"}, done_cnt - base, 1);
   endtask

   task automatic flush();
      tx_en = 1'b0;
      txq.delete();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
   endtask

   function automatic logic [7:0] qget(input int idx, input bit rxq);
      if (rxq) return (idx < rx_log.size()) ? rx_log[idx] : 8'hxx;
      return (idx < wr_log.size()) ? wr_log[idx] : 8'hxx;
   endfunction

   logic [7:0] exp1[3] = '{8'hA5, 8'h3C, 8'hFF};

   initial begin
      int b_wr, b_rx, b_done, b_bad, b_low, b_wl, b_rl, r_cyc, n;

      // ---- reset values ----
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_wr_en", 32'(spi_wr_en), 32'd0);
      check("rst_addr", 32'(spi_addr), 32'h04);
      check("rst_wr_data", spi_wr_data, 32'h0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) cyc_step();

      // ---- three-byte loopback burst ----
      b_wr = wr_cnt; b_rx = rx_cnt; b_bad = cs_bad; b_wl = wr_log.size(); b_rl = rx_log.size();
      txq = '{8'hA5, 8'h3C, 8'hFF};
      tx_en = 1'b1;
      send_cmd("b3", 5'd3);
      wait_done("b3", 200);
      check("b3_error", 32'(done_err), 32'd0);
      check("b3_writes", wr_cnt - b_wr, 3);
      check("b3_rx", rx_cnt - b_rx, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b3_wr_data%0d", i), 32'(qget(b_wl + i, 1'b0)), 32'(exp1[i]));
         check($sformatf("b3_rx_data%0d", i), 32'(qget(b_rl + i, 1'b1)), 32'(exp1[i]));
      end
      check("b3_cs_high_in_burst", cs_bad - b_bad, 0);
      flush();
      repeat (3) cyc_step();

      // ---- zero-length command ----
      b_wr = wr_cnt; b_low = cs_low_cnt;
      send_cmd("z0", 5'd0);
      wait_done("z0", 20);
      check("z0_latency", done_cyc - acc_cyc, 1);
      check("z0_error", 32'(done_err), 32'd0);
      check("z0_writes", wr_cnt - b_wr, 0);
      check("z0_cs_low_cycles", cs_low_cnt - b_low, 0);
      repeat (3) cyc_step();

      // ---- start timeout: peripheral never raises busy ----
      per_nobusy = 1'b1;
      b_wr = wr_cnt; b_rx = rx_cnt;
      txq = '{8'h11, 8'h22};
      tx_en = 1'b1;
      send_cmd("to", 5'd2);
      wait_done("to", 400);
      check("to_error", 32'(done_err), 32'd1);
      check("to_latency", done_cyc - wr_cyc, TIMEOUT + HOLD + 2);
      check("to_writes", wr_cnt - b_wr, 1);
      check("to_rx", rx_cnt - b_rx, 0);
      check("to_cs_high_at_done", 32'(done_cs), 32'd1);
      flush();
      per_nobusy = 1'b0;
      repeat (3) cyc_step();
      @(negedge clk);
      check("to_cs_high_after", 32'(spi_cs_n), 32'd1);
      @(posedge clk);
      #1;

      // ---- tx withheld in LOAD ----
      txq = '{8'h5A};
      tx_en = 1'b0;
      send_cmd("st", 5'd1);
      n = 0;
      while (!tx_ready && (n < 20)) begin
         cyc_step();
         n++;
      end
      check("st_reached_load", 32'(tx_ready), 32'd1);
      b_wr = wr_cnt; b_low = cs_low_cnt;
      repeat (50) cyc_step();
      check("st_no_write", wr_cnt - b_wr, 0);
      check("st_cs_low", cs_low_cnt - b_low, 50);
      tx_en    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = txq[0];
      r_cyc    = cyc;
      b_rl     = rx_log.size();
      wait_done("st", 100);
      check("st_write_latency", wr_cyc - r_cyc, 1);
      check("st_writes", wr_cnt - b_wr, 1);
      check("st_rx_data", 32'(qget(b_rl, 1'b1)), 32'h5A);
      flush();
      repeat (3) cyc_step();

      // ---- reset during WAIT_DONE of byte 2 of 4 ----
      b_wr = wr_cnt;
      txq = '{8'h01, 8'h02, 8'h03, 8'h04};
      tx_en = 1'b1;
      send_cmd("rs", 5'd4);
      n = 0;
      while ((wr_cnt < b_wr + 2) && (n < 200)) begin
         cyc_step();
         n++;
      end
      n = 0;
      while (!per_busy && (n < 20)) begin
         cyc_step();
         n++;
      end
      check("rs_reached_busy", 32'(per_busy), 32'd1);
      cyc_step();
      b_done = done_cnt; b_rx = rx_cnt;
      rst = 1'b1;
      cyc_step();
      rst = 1'b0;
      @(negedge clk);
      check("rs_cs_n", 32'(spi_cs_n), 32'd1);
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      flush();
      repeat (20) cyc_step();
      check("rs_no_done", done_cnt - b_done, 0);
      check("rs_no_rx", rx_cnt - b_rx, 0);

      // ---- oversize length clamps to 16 ----
      b_wr = wr_cnt; b_rx = rx_cnt; b_wl = wr_log.size(); b_rl = rx_log.size();
      for (int i = 0; i < 20; i++) txq.push_back(8'(8'h10 + i));
      tx_en = 1'b1;
      send_cmd("cl", 5'd20);
      wait_done("cl", 1000);
      check("cl_error", 32'(done_err), 32'd0);
      check("cl_writes", wr_cnt - b_wr, 16);
      check("cl_rx", rx_cnt - b_rx, 16);
      check("cl_last_wr", 32'(qget(b_wl + 15, 1'b0)), 32'h1F);
      check("cl_last_rx", 32'(qget(b_rl + 15, 1'b1)), 32'h1F);
      flush();
      repeat (5) cyc_step();
      check("cl_no_extra_writes", wr_cnt - b_wr, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
